// File: rtl/tk_pkg.sv
// Shared definitions for the tweakey load/round sequencer.
// Holds the FSM state encoding, the fixed lane size, the default round
// count and the widths of the internal counters.
package tk_pkg;

  localparam int unsigned NBYTES     = 16;  // tweakey bytes per lane
  localparam int unsigned ROUNDS_DEF = 40;  // default round updates per run
  localparam int unsigned CNT_W      = 4;   // byte counter, 0..NBYTES-1
  localparam int unsigned REM_W      = 3;   // bytes left in word buffer, 0..4
  localparam int unsigned RND_W      = 6;   // round index, 0..62

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOADED,
    ST_SHIFT,
    ST_UPD,
    ST_CORR
  } state_t;

endpackage

// File: rtl/tk_seq.sv
// Tweakey register sequencer.
// Loads 16 tweakey bytes from four 32-bit words into an external byte-serial
// tweakey register, then on start runs ROUNDS rounds of 16 shift cycles plus
// one permutation/LFSR cycle, followed by a single correction cycle.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   din, din_valid       tweakey word input, din[31:24] sent first
//   din_ready            word accepted when din_valid && din_ready
//   start                begin a run (honoured only in LOADED)
//   ki, in               serial byte and input select for the register
//   chain, ksch, correct register shift / round update / end-of-run fix
//   round_idx            current round
//   busy, done           activity flag, one-cycle completion pulse
module tk_seq
  import tk_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             start,
  output logic [7:0]       ki,
  output logic             in,
  output logic             chain,
  output logic             ksch,
  output logic             correct,
  output logic [RND_W-1:0] round_idx,
  output logic             busy,
  output logic             done
);

  state_t             state_q, state_d;
  logic [31:0]        buf_q,   buf_d;
  logic [REM_W-1:0]   rem_q,   rem_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [RND_W-1:0]   rnd_q,   rnd_d;

  // Bytes already emitted plus bytes still waiting in the buffer; once this
  // reaches a full lane no further word may be taken during LOAD.
  logic [CNT_W:0]     committed;

  assign committed = {1'b0, cnt_q} + (CNT_W+1)'(rem_q);
  assign round_idx = rnd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    rnd_d     = rnd_q;
    din_ready = 1'b0;
    ki        = '0;
    in        = 1'b0;
    chain     = 1'b0;
    ksch      = 1'b0;
    correct   = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        din_ready = 1'b1;
      end

      ST_LOAD: begin
        busy      = 1'b1;
        // Ready while the buffer is empty or draining its last byte, so a
        // continuous stream produces back-to-back bytes.
        din_ready = (rem_q <= REM_W'(1)) && (committed < (CNT_W+1)'(NBYTES));
        if (rem_q != '0) begin
          chain = 1'b1;
          in    = 1'b1;
          ki    = buf_q[31:24];
          buf_d = {buf_q[23:0], 8'h00};
          rem_d = rem_q - REM_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NBYTES - 1)) begin
            state_d = ST_LOADED;
          end
        end
      end

      ST_LOADED: begin
        din_ready = !start;
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          rnd_d   = '0;
        end
      end

      ST_SHIFT: begin
        busy  = 1'b1;
        chain = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NBYTES - 1)) begin
          state_d = ST_UPD;
        end
      end

      ST_UPD: begin
        busy = 1'b1;
        ksch = 1'b1;
        if (rnd_q == RND_W'(ROUNDS - 1)) begin
          state_d = ST_CORR;
        end else begin
          rnd_d   = rnd_q + RND_W'(1);
          state_d = ST_SHIFT;
        end
      end

      ST_CORR: begin
        busy    = 1'b1;
        correct = 1'b1;
        done    = 1'b1;
        rnd_d   = '0;
        state_d = ST_LOADED;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Word acceptance overrides the buffer update of the emitting byte; the
    // byte being shifted out this cycle is already on ki.
    if (din_valid && din_ready) begin
      buf_d = din;
      rem_d = REM_W'(4);
      if (state_q != ST_LOAD) begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
    end
  end

endmodule

// File: tb/tb_tk_seq.sv
// Scoreboard bench for tk_seq: stimulus pushes expected output events with
// their cycle numbers; a negedge monitor pops and compares each event.
module tb_tk_seq;

  localparam int unsigned R = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        start = 1'b0;
  logic        din_ready;
  logic [7:0]  ki;
  logic        in_o;
  logic        chain, ksch, correct, busy, done;
  logic [5:0]  round_idx;

  tk_seq #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .start     (start),
    .ki        (ki),
    .in        (in_o),
    .chain     (chain),
    .ksch      (ksch),
    .correct   (correct),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned c;
    logic [19:0] v;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  logic [31:0] W [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};

  logic [19:0] obs;
  assign obs = {ki, in_o, chain, ksch, correct, done, busy, round_idx};

  function automatic logic [19:0] pk(logic [7:0] k, logic i, logic ch, logic ks,
                                     logic co, logic dn, logic bz, logic [5:0] r);
    return {k, i, ch, ks, co, dn, bz, r};
  endfunction

  function automatic void push(int unsigned c, logic [19:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    sbq.push_back(e);
  endfunction

  // Expected events of a run whose start is driven in cycle s; events after
  // cycle lim are omitted (run aborted by reset).
  function automatic void push_run(int unsigned s, int unsigned lim);
    int unsigned c;
    for (int unsigned r = 0; r < R; r++) begin
      for (int unsigned j = 0; j < 16; j++) begin
        c = s + 1 + 17 * r + j;
        if (c <= lim) push(c, pk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'(r)));
      end
      c = s + 17 + 17 * r;
      if (c <= lim) push(c, pk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'(r)));
    end
    c = s + 1 + 17 * R;
    if (c <= lim) push(c, pk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'(R - 1)));
  endfunction

  // Monitor: any register command or serial data counts as an output event.
  always @(negedge clk) begin
    if (mon_en && (chain || ksch || correct || done || in_o || (ki != 8'h00))) begin
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got=%h required=none", cyc, obs);
      end else begin
        e = sbq.pop_front();
        if (e.c != cyc || e.v != obs) begin
          errors++;
          $display("FAIL event cyc=%0d got=%h required=%h at cyc %0d", cyc, obs, e.v, e.c);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h required=%h", n, cyc, got, exp);
    end
  endtask

  // Offer a word now (caller sits just after a negedge) and hold it until
  // din_ready is seen; acceptance happens at the following posedge.
  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      #1;
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout cyc=%0d got=din_ready 0 required=1", cyc);
    end
  endtask

  // Load the four words; with gap, din_valid drops for the three cycles in
  // which word 2 would otherwise have been taken, and start is pulsed then.
  task automatic load(input bit gap, output int unsigned a);
    a = cyc;
    for (int unsigned i = 0; i < 16; i++)
      push(a + 1 + i + ((gap && i >= 8) ? 3 : 0),
           pk(8'(i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0));
    send_word(W[0]);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      if (gap && k == 2) begin
        din_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
      end
      send_word(W[k]);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=no finish required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a, s;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("reset_hold", {11'h0, din_ready, obs}, 32'h0010_0000);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("reset_idle", {11'h0, din_ready, obs}, 32'h0010_0000);
    mon_en = 1'b1;

    // Continuous load from IDLE: 16 bytes on a+1..a+16, LOADED at a+17.
    load(1'b0, a);
    while (cyc < a + 17) @(negedge clk);
    #1 chk("loaded_ready", {31'h0, din_ready}, 32'h1);
    chk("loaded_busy", {31'h0, busy}, 32'h0);

    // Full run; start collides with a valid word, and start is re-pulsed mid-run.
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    din_valid = 1'b1;
    din = 32'hDEADBEEF;
    #1 chk("collide_ready", {31'h0, din_ready}, 32'h0);
    push_run(s, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b0;
    din_valid = 1'b0;
    while (cyc < s + 50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 682) @(negedge clk);
    #1 chk("after_run", {11'h0, din_ready, obs}, 32'h0010_0000);

    // Reload from LOADED with a din_valid gap: 19-cycle load.
    @(negedge clk);
    load(1'b1, a);
    while (cyc < a + 20) @(negedge clk);
    #1 chk("gap_loaded_ready", {31'h0, din_ready}, 32'h1);
    chk("gap_loaded_busy", {31'h0, busy}, 32'h0);

    // Run aborted by reset in round 7, shift cycle 5.
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    push_run(s, s + 125);
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 125) @(negedge clk);
    #1 chk("pre_abort_round", {26'h0, round_idx}, 32'd7);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("rst_abort", {11'h0, din_ready, obs}, 32'h0010_0000);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("rst_abort_idle", {11'h0, din_ready, obs}, 32'h0010_0000);

    repeat (30) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tk_seq.md
TK_SEQ -- requirements
Module: tk_seq

Interface
REQ-001 Parameter ROUNDS, default 40, number of round updates per run (1..63).
REQ-002 Parameter NBYTES, fixed at 16, tweakey bytes per lane.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din  input  32  tweakey word; din[31:24] is the first byte sent.
REQ-006 din_valid  input  1  din holds a valid word.
REQ-007 din_ready  output  1  block accepts din on this cycle.
REQ-008 start  input  1  begin a round run on the loaded tweakey.
REQ-009 ki  output  8  byte to the tweakey register's serial input.
REQ-010 in  output  1  select ki (1) or recirculate (0) at the register input.
REQ-011 chain  output  1  shift the tweakey register by one byte.
REQ-012 ksch  output  1  apply one round permutation and LFSR step.
REQ-013 correct  output  1  apply the end-of-run correction.
REQ-014 round_idx  output  6  current round, 0..ROUNDS-1.
REQ-015 busy  output  1  state is LOAD, SHIFT, UPD or CORR.
REQ-016 done  output  1  one-cycle pulse when a run completes.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, LOADED, SHIFT, UPD and CORR.
REQ-018 At most one of chain, ksch and correct SHALL be high in any cycle.
REQ-019 A word SHALL be accepted on a cycle where din_valid and din_ready are both high.
REQ-020 din_ready SHALL be high in IDLE, in LOADED when start=0, and in LOAD when the word buffer is empty or emitting its 4th byte; otherwise din_ready SHALL be low.
REQ-021 An accepted word SHALL be emitted over the next 4 cycles, MSB byte first, with chain=1, in=1 and ki set to the byte.
REQ-022 A load SHALL deliver exactly 4 words (16 bytes), with no gaps when din_valid is held high; the first byte SHALL end in the register's output byte.
REQ-023 Gaps in din_valid during LOAD SHALL produce cycles with chain=0, and shifting SHALL pause.
REQ-024 After the 16th byte the FSM SHALL enter LOADED.
REQ-025 Acceptance in IDLE or LOADED SHALL enter LOAD and restart the byte count at 0.
REQ-026 start in LOADED SHALL enter SHIFT with round_idx=0; start in any other state SHALL be ignored.
REQ-027 SHIFT SHALL last exactly 16 cycles with chain=1 and in=0, then enter UPD.
REQ-028 UPD SHALL last 1 cycle with ksch=1; if round_idx=ROUNDS-1 it SHALL then enter CORR, otherwise round_idx SHALL increment and the FSM SHALL re-enter SHIFT.
REQ-029 CORR SHALL last 1 cycle with correct=1, assert done in the same cycle, and return to LOADED with round_idx=0.
REQ-030 A run SHALL take 17*ROUNDS+1 cycles from the first SHIFT cycle to done (681 at default).
REQ-031 ki SHALL be 0 and in SHALL be 0 whenever no byte is being loaded.

Reset
REQ-032 While rst=1, the state SHALL become IDLE, and the byte counter, round_idx and word buffer SHALL be cleared.
REQ-033 After reset, every output SHALL be 0, except din_ready, which SHALL be 1 in IDLE.
REQ-034 Reset asserted mid-load or mid-run SHALL abort without a correct or done pulse; the tweakey register content is then undefined and a reload is required.

Structure
REQ-035 Package tk_pkg SHALL hold the state enum, NBYTES=16, the default ROUNDS=40 and the counter widths.
REQ-036 The module SHALL be a single flat FSM plus counters, with no sub-module.

Verification
REQ-037 Load words 0x00010203, 0x04050607, 0x08090A0B and 0x0C0D0E0F with din_valid held high -> ki sequence 00..0F on 16 consecutive cycles with chain=in=1, then LOADED.
REQ-038 Same load with a 3-cycle din_valid gap after word 1 -> 3 chain=0 cycles, identical byte order, 19-cycle load.
REQ-039 start with ROUNDS=40 -> 40 patterns of 16 chain cycles and 1 ksch cycle, correct and done at cycle 681, round_idx back to 0.
REQ-040 start and din_valid both high in LOADED -> din_ready=0, run begins, word not accepted.
REQ-041 rst at SHIFT cycle 5 of round 7 -> next cycle IDLE, all outputs 0 except din_ready=1, no done.
REQ-042 start pulsed during LOAD and during SHIFT -> ignored, timing unchanged.
